// File: rtl/mem_wb_if.sv
// MEM -> WB pipeline bundle: MEM-stage fields in, registered write-back fields out.
// The master side drives the MEM fields; the WB stage is the slave.
interface mem_wb_if;
  logic        Mem_Valid;
  logic [31:0] Mem_Alu_R;
  logic [31:0] Dout;
  logic [4:0]  Mem_Rn;
  logic        Mem_Wreg;
  logic        Mem_M2reg;

  logic        Wb_Valid;
  logic [4:0]  Wb_Rn;
  logic        Wb_Wreg;
  logic [31:0] Wb_Data;

  modport master (
    output Mem_Valid, Mem_Alu_R, Dout, Mem_Rn, Mem_Wreg, Mem_M2reg,
    input  Wb_Valid, Wb_Rn, Wb_Wreg, Wb_Data
  );

  modport slave (
    input  Mem_Valid, Mem_Alu_R, Dout, Mem_Rn, Mem_Wreg, Mem_M2reg,
    output Wb_Valid, Wb_Rn, Wb_Wreg, Wb_Data
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux, r0 suppression and retired counter.
// Optional EX-stage forwarding outputs are enabled by defining MEMWB_FWD_EN.
module mem_wb_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             stall,
  input  logic             flush,
  mem_wb_if.slave          bus,
  output logic [CNT_W-1:0] Retired
`ifdef MEMWB_FWD_EN
  ,
  output logic             Fwd_Valid,
  output logic [4:0]       Fwd_Rn,
  output logic [31:0]      Fwd_Data
`endif
);

  logic             valid_q, valid_d;
  logic [31:0]      alu_q, alu_d;
  logic [31:0]      dout_q, dout_d;
  logic [4:0]       rn_q, rn_d;
  logic             wreg_q, wreg_d;
  logic             m2reg_q, m2reg_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wr_qual;

  // Priority: clr > flush > stall > capture. Flush also freezes the counter.
  always_comb begin
    valid_d   = valid_q;
    alu_d     = alu_q;
    dout_d    = dout_q;
    rn_d      = rn_q;
    wreg_d    = wreg_q;
    m2reg_d   = m2reg_q;
    retired_d = retired_q;
    if (clr) begin
      valid_d   = 1'b0;
      alu_d     = 32'd0;
      dout_d    = 32'd0;
      rn_d      = 5'd0;
      wreg_d    = 1'b0;
      m2reg_d   = 1'b0;
      retired_d = '0;
    end else if (flush) begin
      valid_d = 1'b0;
      alu_d   = 32'd0;
      dout_d  = 32'd0;
      rn_d    = 5'd0;
      wreg_d  = 1'b0;
      m2reg_d = 1'b0;
    end else if (!stall) begin
      valid_d   = bus.Mem_Valid;
      alu_d     = bus.Mem_Alu_R;
      dout_d    = bus.Dout;
      rn_d      = bus.Mem_Rn;
      wreg_d    = bus.Mem_Wreg;
      m2reg_d   = bus.Mem_M2reg;
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, valid_q};
    end
  end

  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    alu_q     <= alu_d;
    dout_q    <= dout_d;
    rn_q      <= rn_d;
    wreg_q    <= wreg_d;
    m2reg_q   <= m2reg_d;
    retired_q <= retired_d;
  end

  // Architectural write intent, independent of stall.
  assign wr_qual = valid_q & wreg_q & (rn_q != 5'd0);

  assign bus.Wb_Valid = valid_q;
  assign bus.Wb_Rn    = rn_q;
  assign bus.Wb_Data  = m2reg_q ? dout_q : alu_q;
  // Held instructions write only on their final, non-stalled cycle.
  assign bus.Wb_Wreg  = wr_qual & ~stall;
  assign Retired      = retired_q;

`ifdef MEMWB_FWD_EN
  assign Fwd_Valid = wr_qual;
  assign Fwd_Rn    = rn_q;
  assign Fwd_Data  = bus.Wb_Data;
`endif

endmodule
